// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle fader for the 8-bit PWM stage: steps duty_cycle toward a loaded target once per prescaled tick.
// Optional continuous "breathe" mode is enabled by defining PWM_FADE_BREATHE_EN.
module pwm_fade_ctrl #(
    parameter int TICK_DIV   = 390_625,
    parameter int PRESCALE_W = $clog2(TICK_DIV)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] target,
    input  logic [3:0] step,
`ifdef PWM_FADE_BREATHE_EN
    input  logic       breathe,
`endif
    output logic [7:0] duty_cycle,
    output logic       busy,
    output logic       done
);

    typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_t;

    localparam logic [PRESCALE_W-1:0] TICK_LAST = PRESCALE_W'(TICK_DIV - 1);

    state_t                state_q, state_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [7:0]            duty_q, duty_d;
    logic [7:0]            tgt_q, tgt_d;
    logic [7:0]            dest_q, dest_d;
    logic [3:0]            step_q, step_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  breathe_w;
    logic                  tick;
    logic                  arrive;
    logic                  load_same;
    logic [8:0]            diff;

`ifdef PWM_FADE_BREATHE_EN
    assign breathe_w = breathe;
`else
    assign breathe_w = 1'b0;
`endif

    // dest_q is the endpoint of the ramp in flight; it differs from tgt_q only while breathing back to 0.
    assign tick      = (state_q == RAMP) && (presc_q == TICK_LAST);
    assign diff      = (dest_q >= duty_q) ? ({1'b0, dest_q} - {1'b0, duty_q})
                                          : ({1'b0, duty_q} - {1'b0, dest_q});
    assign arrive    = tick && (diff <= {5'd0, step_q});
    assign load_same = (target == duty_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            duty_q  <= 8'd0;
            tgt_q   <= 8'd0;
            dest_q  <= 8'd0;
            step_q  <= 4'd1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
            dest_q  <= dest_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        duty_d  = duty_q;
        tgt_d   = tgt_q;
        dest_d  = dest_q;
        step_d  = step_q;
        if (load) begin
            tgt_d   = target;
            dest_d  = target;
            step_d  = (step == 4'd0) ? 4'd1 : step;
            presc_d = '0;
            state_d = load_same ? IDLE : RAMP;
        end else if (state_q == RAMP) begin
            presc_d = tick ? '0 : presc_q + PRESCALE_W'(1);
            if (arrive) begin
                duty_d = dest_q;
                if (breathe_w) begin
                    dest_d = (dest_q == tgt_q) ? 8'd0 : tgt_q;
                end else begin
                    state_d = IDLE;
                end
            end else if (tick) begin
                // diff > step here, so neither direction can wrap past 0 or 255.
                if (dest_q > duty_q) begin
                    duty_d = duty_q + {4'd0, step_q};
                end else begin
                    duty_d = duty_q - {4'd0, step_q};
                end
            end
        end
    end

    always_comb begin
        busy_d = (state_d == RAMP);
        done_d = load ? load_same : (arrive && !breathe_w);
    end

    assign duty_cycle = duty_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Scoreboard bench for pwm_fade_ctrl with TICK_DIV=4: stimulus queues expected
// (duty, done, busy, cycle) events; a negedge monitor pops and compares each DUT change.
module tb_pwm_fade_ctrl;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [7:0] target = 8'd0;
    logic [3:0] step = 4'd0;
`ifdef PWM_FADE_BREATHE_EN
    logic       breathe = 1'b0;
`endif
    logic [7:0] duty_cycle;
    logic       busy;
    logic       done;

    pwm_fade_ctrl #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .target     (target),
        .step       (step),
`ifdef PWM_FADE_BREATHE_EN
        .breathe    (breathe),
`endif
        .duty_cycle (duty_cycle),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  duty;
        logic        done;
        logic        busy;
        logic [31:0] cyc;
    } ev_t;

    ev_t  exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   n0 = 0;
    logic [7:0] prev_duty = 8'd0;

    always @(posedge clk) cyc++;

    // Monitor: any duty change or done pulse is an output event.
    always @(negedge clk) begin
        if (rst) begin
            prev_duty = duty_cycle;
        end else if (duty_cycle != prev_duty || done) begin
            ev_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d got duty=%0d done=%0b busy=%0b, required no event",
                         cyc, duty_cycle, done, busy);
            end else begin
                e = exp_q.pop_front();
                if (e.duty != duty_cycle || e.done != done || e.busy != busy || e.cyc != 32'(cyc)) begin
                    errors++;
                    $display("FAIL event got duty=%0d done=%0b busy=%0b cyc=%0d, required duty=%0d done=%0b busy=%0b cyc=%0d",
                             duty_cycle, done, busy, cyc, e.duty, e.done, e.busy, e.cyc);
                end else begin
                    $display("ok   event duty=%0d done=%0b busy=%0b cyc=%0d", duty_cycle, done, busy, cyc);
                end
            end
            prev_duty = duty_cycle;
        end
    end

    task automatic push(input int d, input bit dn, input bit b, input int c);
        exp_q.push_back({8'(d), dn, b, 32'(c)});
    endtask

    // One-cycle load; n0 is the edge number that samples it.
    task automatic do_load(input int t, input int s);
        @(posedge clk); #2;
        target = 8'(t);
        step   = 4'(s);
        load   = 1'b1;
        n0     = cyc + 1;
        @(posedge clk); #2;
        load   = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s pending=%0d, required 0 within %0d cycles", name, exp_q.size(), budget);
            exp_q.delete();
        end
        repeat (2 * TD) @(posedge clk);
    endtask

    task automatic check_direct(input string name, input logic [7:0] d, input logic b, input logic dn);
        checks++;
        if (duty_cycle !== d || busy !== b || done !== dn) begin
            errors++;
            $display("FAIL %s got duty=%0d busy=%0b done=%0b, required duty=%0d busy=%0b done=%0b",
                     name, duty_cycle, busy, done, d, b, dn);
        end else begin
            $display("ok   %s duty=%0d busy=%0b done=%0b", name, duty_cycle, busy, done);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #3;
        check_direct("reset_state", 8'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Test 1: async reset mid-ramp
        do_load(200, 5);
        for (int k = 1; k <= 3; k++) push(5 * k, 1'b0, 1'b1, n0 + TD * k);
        while (exp_q.size() != 0 && cyc < n0 + 40) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_direct("async_reset", 8'd0, 1'b0, 1'b0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3;
        check_direct("reset_hold", 8'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Test 2: 0 -> 10 step 3
        do_load(10, 3);
        push(3, 1'b0, 1'b1, n0 + 4);
        push(6, 1'b0, 1'b1, n0 + 8);
        push(9, 1'b0, 1'b1, n0 + 12);
        push(10, 1'b1, 1'b0, n0 + 16);
        drain("ramp_0_10", 40);

        // Test 4: load equal to current duty
        do_load(10, 7);
        push(10, 1'b1, 1'b0, n0);
        drain("same_target", 10);
        check_direct("same_target_hold", 8'd10, 1'b0, 1'b0);

        // Test 3: 10 -> 250 step 15, then 250 -> 255, then 255 -> 0 step 0 (as 1)
        do_load(250, 15);
        for (int k = 1; k <= 14; k++) push(10 + 15 * k, 1'b0, 1'b1, n0 + TD * k);
        push(235, 1'b0, 1'b1, n0 + TD * 15);
        push(250, 1'b1, 1'b0, n0 + TD * 16);
        drain("ramp_10_250", 100);

        do_load(255, 15);
        push(255, 1'b1, 1'b0, n0 + 4);
        drain("ramp_250_255", 20);

        do_load(0, 0);
        for (int k = 1; k <= 255; k++) push(255 - k, k == 255, k != 255, n0 + TD * k);
        drain("ramp_255_0", 1100);
        check_direct("floor_hold", 8'd0, 1'b0, 1'b0);

        // Test 5: retarget at duty=50 during 0 -> 200
        do_load(200, 5);
        for (int k = 1; k <= 10; k++) push(5 * k, 1'b0, 1'b1, n0 + TD * k);
        while (cyc < n0 + 40) @(posedge clk);
        #2;
        target = 8'd20;
        step   = 4'd5;
        load   = 1'b1;
        n0     = cyc + 1;
        @(posedge clk); #2;
        load   = 1'b0;
        for (int k = 1; k <= 5; k++) push(50 - 5 * k, 1'b0, 1'b1, n0 + TD * k);
        push(20, 1'b1, 1'b0, n0 + TD * 6);
        drain("retarget", 100);

`ifdef PWM_FADE_BREATHE_EN
        // Test 6: breathe between 8 and 0, then release while rising
        do_load(0, 15);
        push(5, 1'b0, 1'b1, n0 + 4);
        push(0, 1'b1, 1'b0, n0 + 8);
        drain("to_zero", 20);
        breathe = 1'b1;
        do_load(8, 4);
        push(4, 1'b0, 1'b1, n0 + 4);
        push(8, 1'b0, 1'b1, n0 + 8);
        push(4, 1'b0, 1'b1, n0 + 12);
        push(0, 1'b0, 1'b1, n0 + 16);
        push(4, 1'b0, 1'b1, n0 + 20);
        push(8, 1'b1, 1'b0, n0 + 24);
        while (cyc < n0 + 20) @(posedge clk);
        #2;
        breathe = 1'b0;
        drain("breathe", 40);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d, required completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
